// File: rtl/tt_sweep.sv
// tt_sweep: walks every input vector through two DUTs and captures both truth tables; optional mismatch_cnt via TT_SWEEP_MISMATCH_COUNT_EN.
// Latency: done rises exactly 2**WIDTH*SETTLE cycles after the start-accept edge.
// Backpressure: none; start is ignored during a sweep, and in DONE it restarts the sweep.
module tt_sweep #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [WIDTH-1:0]        x_out,
    input  logic                    r_a,
    input  logic                    r_b,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<WIDTH)-1:0]   tt_a,
    output logic [(1<<WIDTH)-1:0]   tt_b,
    output logic                    equal,
    output logic [WIDTH-1:0]        first_bad
`ifdef TT_SWEEP_MISMATCH_COUNT_EN
    ,
    output logic [WIDTH:0]          mismatch_cnt
`endif
);

    localparam int               NVEC      = 1 << WIDTH;
    localparam logic [WIDTH-1:0] VEC_LAST  = WIDTH'(NVEC - 1);
    localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] vec;
    logic [3:0]       cnt;
    logic             accept;
    logic             capture;
    logic             last;
    logic [NVEC-1:0]  tt_a_nxt;
    logic [NVEC-1:0]  tt_b_nxt;
    logic [NVEC-1:0]  diff;
    logic [WIDTH-1:0] first_bad_nxt;

    assign accept  = (state != DRIVE) && start;
    assign capture = (state == DRIVE) && (cnt == SETTLE_M1);
    assign last    = (vec == VEC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (capture && last) state_nxt = DONE;
            DONE:    if (start) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tables including the bit being captured this edge, so the compare
    // result can be registered on the same edge that enters DONE.
    always_comb begin
        tt_a_nxt      = tt_a;
        tt_b_nxt      = tt_b;
        tt_a_nxt[vec] = r_a;
        tt_b_nxt[vec] = r_b;
        diff          = tt_a_nxt ^ tt_b_nxt;
        first_bad_nxt = '0;
        for (int i = NVEC - 1; i >= 0; i--) begin
            if (diff[i]) first_bad_nxt = WIDTH'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            cnt       <= '0;
            tt_a      <= '0;
            tt_b      <= '0;
            equal     <= 1'b0;
            first_bad <= '0;
        end else if (accept) begin
            vec       <= '0;
            cnt       <= '0;
            tt_a      <= '0;
            tt_b      <= '0;
            equal     <= 1'b0;
            first_bad <= '0;
        end else if (capture) begin
            tt_a <= tt_a_nxt;
            tt_b <= tt_b_nxt;
            if (last) begin
                equal     <= (diff == '0);
                first_bad <= first_bad_nxt;
            end else begin
                vec <= vec + WIDTH'(1);
                cnt <= '0;
            end
        end else if (state == DRIVE) begin
            cnt <= cnt + 4'd1;
        end
    end

`ifdef TT_SWEEP_MISMATCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt <= '0;
        end else if (accept) begin
            mismatch_cnt <= '0;
        end else if (capture && (r_a != r_b)) begin
            mismatch_cnt <= mismatch_cnt + (WIDTH+1)'(1);
        end
    end
`endif

    // vec parks on the last vector in DONE, which is the required DONE drive value.
    assign x_out = (state == IDLE) ? '0 : vec;
    assign busy  = (state == DRIVE);
    assign done  = (state == DONE);

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of DUT input bits swept (1..4).
REQ-002 SHALL have parameter SETTLE, default 1, number of clock cycles each vector is held before sampling (1..15).
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a sweep.
REQ-006 SHALL have port x_out, output, WIDTH, input vector driven to both DUTs; x_out[WIDTH-1] is the first operand (x), x_out[0] is the last (y).
REQ-007 SHALL have port r_a, input, 1, result of DUT A (gate-level form).
REQ-008 SHALL have port r_b, input, 1, result of DUT B (expression form).
REQ-009 SHALL have port busy, output, 1, sweep in progress.
REQ-010 SHALL have port done, output, 1, sweep complete; results valid.
REQ-011 SHALL have port tt_a, output, 2**WIDTH, captured truth table of r_a; bit i = r_a at vector i.
REQ-012 SHALL have port tt_b, output, 2**WIDTH, captured truth table of r_b.
REQ-013 SHALL have port equal, output, 1, tt_a == tt_b; meaningful only while done=1.
REQ-014 SHALL have port first_bad, output, WIDTH, lowest vector index where tt_a and tt_b differ; 0 when equal=1.

Function
REQ-015 SHALL implement states IDLE, DRIVE, DONE.
REQ-016 IDLE: start=1 at an edge SHALL clear tt_a, tt_b, vec and settle count, enter DRIVE, and assert busy.
REQ-017 DRIVE SHALL drive x_out = vec and count SETTLE cycles.
REQ-018 At the edge ending the SETTLE-th DRIVE cycle, the block SHALL write r_a into tt_a[vec] and r_b into tt_b[vec].
REQ-019 After that write, if vec = 2**WIDTH-1 the block SHALL enter DONE; otherwise it SHALL increment vec and restart the settle count.
REQ-020 Sweep latency SHALL be exactly 2**WIDTH*SETTLE cycles from the start-accept edge to the edge that asserts done.
REQ-021 DONE SHALL hold done=1, busy=0, x_out = 2**WIDTH-1, and keep tt_a, tt_b, equal and first_bad stable until the next accepted start.
REQ-022 start=1 in DONE SHALL behave as in IDLE: clear, restart and deassert done on the same edge.
REQ-023 start SHALL be ignored while in DRIVE; an in-flight sweep SHALL NOT restart.
REQ-024 equal and first_bad SHALL be registered and updated on the edge entering DONE; first_bad SHALL be the lowest differing index.
REQ-025 busy and done SHALL never be 1 simultaneously.
REQ-026 r_a and r_b SHALL be sampled only at capture edges; toggles at other times SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE and clear vec, settle count, x_out, tt_a, tt_b and first_bad to 0, and force busy=0, done=0 and equal=0, regardless of clock.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no partial results retained.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With TT_SWEEP_MISMATCH_COUNT_EN defined, the block SHALL add output mismatch_cnt (WIDTH+1 bits).
REQ-031 mismatch_cnt SHALL be cleared on start and on reset, and SHALL increment on each capture where r_a != r_b.
REQ-032 mismatch_cnt SHALL be final when done=1.
REQ-033 Without TT_SWEEP_MISMATCH_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 WIDTH=2, SETTLE=1, r_a = r_b = x&~y, start pulse -> done after 4 cycles, tt_a = tt_b = 4'b0100, equal=1, first_bad=0.
REQ-035 WIDTH=2, SETTLE=2, r_a = x&~y, r_b = x|~y -> done after 8 cycles, tt_a=4'b0100, tt_b=4'b1101, equal=0, first_bad=0, mismatch_cnt=2 (macro on).
REQ-036 start held high for the whole sweep -> single sweep with no restart; with start still high in DONE, a new sweep begins on the next edge and done deasserts.
REQ-037 rst_n pulled low while vec=2 -> outputs at reset values immediately; a new start gives a full clean sweep with correct tables.
REQ-038 r_a glitched between capture edges (SETTLE=3) -> tt_a reflects only the capture-edge values; x_out holds each vector for exactly 3 cycles.
REQ-039 Build without the macro -> mismatch_cnt absent; REQ-034 and REQ-035 table, equal and first_bad results unchanged.
